id_stage: RTL and testbench

Registered instruction-decode stage feeding the execute-stage ALU. It accepts a fetched 32-bit RV32I instruction and reads the register file. It then produces operand_a, operand_b, funct3, funct7_bit5 and alu_op in the ALU's encoding, plus writeback and illegal-instruction controls. All outputs come from one pipeline register with a valid/ready handshake, which sits between fetch and execute.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/imm_gen.sv | 26 ++
 rtl/id_stage.sv | 133 +++++++++++++
 tb/tb_id_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: datapath width, ALU operation codes, major opcodes
// and the registered decode bundle.
package rv_pkg;
  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [2:0]      funct3;
    logic            funct7_bit5;
    logic [3:0]      alu_op;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } id_bundle_t;
endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: sign-extended I/S/B/U/J immediate
// selected by the instruction's opcode; unknown opcodes yield zero.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = imm_i;
      OPC_STORE:                      imm = imm_s;
      OPC_BRANCH:                     imm = imm_b;
      OPC_LUI, OPC_AUIPC:             imm = imm_u;
      OPC_JAL:                        imm = imm_j;
      default:                        imm = '0;
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage: decodes the fetched instruction into ALU operands and
// controls, held in one valid/ready pipeline register between fetch and execute.
module id_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [2:0]      funct3,
  output logic            funct7_bit5,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);
  import rv_pkg::*;

  logic        valid_q, valid_d;
  id_bundle_t  bundle_q, bundle_d, dec;
  logic [31:0] imm;
  logic [2:0]  f3;

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign f3       = in_instr[14:12];
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    dec             = '0;
    dec.funct3      = f3;
    dec.rd_addr     = in_instr[11:7];
    dec.pc          = in_pc;
    case (in_instr[6:0])
      OPC_OP: begin
        dec.operand_a   = rs1_data;
        dec.operand_b   = rs2_data;
        dec.alu_op      = {1'b0, f3};
        dec.funct7_bit5 = in_instr[30];
        dec.rd_we       = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.operand_a   = rs1_data;
        dec.operand_b   = imm;
        dec.alu_op      = {1'b0, f3};
        // instr[30] is immediate data except for shifts; keeps ADDI from subtracting
        dec.funct7_bit5 = (f3 == 3'b101) && in_instr[30];
        dec.rd_we       = 1'b1;
      end
      OPC_LOAD, OPC_JALR: begin
        dec.operand_a = rs1_data;
        dec.operand_b = imm;
        dec.rd_we     = 1'b1;
      end
      OPC_STORE: begin
        dec.operand_a = rs1_data;
        dec.operand_b = imm;
      end
      OPC_LUI: begin
        dec.operand_b = imm;
        dec.rd_we     = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec.operand_a = in_pc;
        dec.operand_b = imm;
        dec.rd_we     = 1'b1;
      end
      OPC_BRANCH: begin
        dec.operand_a = rs1_data;
        dec.operand_b = rs2_data;
        case (f3[2:1])
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: begin
            dec.alu_op      = ALU_ADD;
            dec.funct7_bit5 = 1'b1;
          end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    if (in_instr[11:7] == 5'd0) dec.rd_we = 1'b0;
  end

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) bundle_d = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid   = valid_q;
  assign operand_a   = bundle_q.operand_a;
  assign operand_b   = bundle_q.operand_b;
  assign funct3      = bundle_q.funct3;
  assign funct7_bit5 = bundle_q.funct7_bit5;
  assign alu_op      = bundle_q.alu_op;
  assign rd_addr     = bundle_q.rd_addr;
  assign rd_we       = bundle_q.rd_we;
  assign out_pc      = bundle_q.pc;
  assign illegal     = bundle_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus a randomized stream checked
// against a one-entry behavioural model of the decode register.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] operand_a, operand_b, out_pc;
  logic [2:0]  funct3;
  logic        funct7_bit5, rd_we, illegal;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b), .funct3(funct3),
    .funct7_bit5(funct7_bit5), .alu_op(alu_op), .rd_addr(rd_addr), .rd_we(rd_we),
    .out_pc(out_pc), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] a, b, pc;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  int   npass = 0;
  int   ntotal = 0;
  logic m_full = 1'b0;
  exp_t m_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'd1 << (bits - 1);
    return (v ^ m) - m;
  endfunction

  // Decode rules expressed as field arithmetic on the instruction word
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [31:0] i_imm, s_imm, u_imm, j_imm;
    logic [6:0]  opc;
    opc   = 7'(w % 128);
    i_imm = sext(w >> 20, 12);
    s_imm = sext(((w >> 25) << 5) + ((w >> 7) % 32), 12);
    u_imm = w & 32'hFFFF_F000;
    j_imm = sext((((w >> 31) % 2) << 20) + (((w >> 12) % 256) << 12)
                 + (((w >> 20) % 2) << 11) + (((w >> 21) % 1024) << 1), 21);
    e = '{a: 0, b: 0, pc: pc, f3: 3'((w >> 12) % 8), f7: 0, op: 0,
          rd: 5'((w >> 7) % 32), we: 0, ill: 0};
    case (opc)
      7'h33: begin e.a = r1; e.b = r2; e.op = {1'b0, e.f3}; e.f7 = w[30]; e.we = 1; end
      7'h13: begin
        e.a = r1; e.b = i_imm; e.op = {1'b0, e.f3}; e.we = 1;
        e.f7 = (e.f3 == 5) ? w[30] : 1'b0;
      end
      7'h03, 7'h67: begin e.a = r1; e.b = i_imm; e.we = 1; end
      7'h23: begin e.a = r1; e.b = s_imm; end
      7'h37: begin e.b = u_imm; e.we = 1; end
      7'h17: begin e.a = pc; e.b = u_imm; e.we = 1; end
      7'h6F: begin e.a = pc; e.b = j_imm; e.we = 1; end
      7'h63: begin
        e.a = r1; e.b = r2;
        if (e.f3 < 2) e.f7 = 1;
        else if (e.f3 < 6) e.op = 4'd2;
        else e.op = 4'd3;
      end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  task automatic check_out();
    check("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      check("operand_a", operand_a, m_b.a);
      check("operand_b", operand_b, m_b.b);
      check("funct3", 32'(funct3), 32'(m_b.f3));
      check("funct7_bit5", 32'(funct7_bit5), 32'(m_b.f7));
      check("alu_op", 32'(alu_op), 32'(m_b.op));
      check("rd_addr", 32'(rd_addr), 32'(m_b.rd));
      check("rd_we", 32'(rd_we), 32'(m_b.we));
      check("out_pc", out_pc, m_b.pc);
      check("illegal", 32'(illegal), 32'(m_b.ill));
    end
  endtask

  // One clock: drive, check pre-edge state, advance, update the model
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic        er;
    logic [31:0] pc;
    pc = $urandom;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    er = !m_full || ordy;
    check("in_ready", 32'(in_ready), 32'(er));
    check("rs1_addr", 32'(rs1_addr), (ins >> 15) % 32);
    check("rs2_addr", 32'(rs2_addr), (ins >> 20) % 32);
    check_out();
    @(posedge clk);
    #1;
    if (fl) m_full = 0;
    else if (er) begin
      m_full = v;
      if (v) m_b = model(ins, pc, rf[(ins >> 15) % 32], rf[(ins >> 20) % 32]);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [11];
    logic [2:0]  bf3 [6];
    logic [31:0] w;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h7F, 7'h00};
    bf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    w = $urandom;
    w = (w & 32'hFFFF_FF80) | 32'(opcs[$urandom_range(0, 10)]);
    if (w[6:0] == 7'h63) w = (w & ~32'h0000_7000) | (32'(bf3[$urandom_range(0, 5)]) << 12);
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0; rf[1] = 7; rf[2] = 5;

    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst operand_a", operand_a, 0);
    check("rst operand_b", operand_b, 0);
    check("rst alu_op", 32'(alu_op), 0);
    check("rst illegal", 32'(illegal), 0);
    check("rst rd_we", 32'(rd_we), 0);
    check("rst out_pc", out_pc, 0);
    check("rst in_ready", 32'(in_ready), 1);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    cycle(1, 32'hFFF00093, 1, 0);                     // ADDI x1,x0,-1
    check("addi b", operand_b, 32'hFFFF_FFFF);
    check("addi op", 32'(alu_op), 0);
    check("addi f7", 32'(funct7_bit5), 0);
    check("addi rd", 32'(rd_addr), 1);
    check("addi we", 32'(rd_we), 1);
    cycle(1, 32'h4030D113, 1, 0);                     // SRAI x2,x1,3
    check("srai op", 32'(alu_op), 5);
    check("srai f7", 32'(funct7_bit5), 1);
    check("srai shamt", operand_b % 32, 3);
    cycle(1, 32'h0020E063, 1, 0);                     // BLTU x1,x2
    check("bltu op", 32'(alu_op), 3);
    check("bltu we", 32'(rd_we), 0);
    cycle(1, 32'h00000FFF, 1, 0);                     // opcode 0x7F, rd 31
    check("ill illegal", 32'(illegal), 1);
    check("ill we", 32'(rd_we), 0);
    cycle(1, 32'h00208033, 1, 0);                     // ADD x0,x1,x2
    check("x0 we", 32'(rd_we), 0);
    cycle(1, 32'h402081B3, 1, 0);                     // SUB x3,x1,x2
    check("sub op", 32'(alu_op), 0);
    check("sub f7", 32'(funct7_bit5), 1);
    check("sub a", operand_a, 7);
    check("sub b", operand_b, 5);

    for (int i = 0; i < 3; i++) begin                 // stall with SUB held
      cycle(1, rand_instr(), 0, 0);
      check("stall in_ready", 32'(in_ready), 0);
      check("stall a", operand_a, 7);
    end
    cycle(1, 32'hFFF00093, 1, 0);
    check("release rd", 32'(rd_addr), 1);

    for (int i = 0; i < 8; i++) begin                 // back-to-back stream
      cycle(1, rand_instr(), 1, 0);
      check("b2b valid", 32'(out_valid), 1);
    end

    cycle(1, 32'h402081B3, 0, 0);                     // flush held and incoming
    cycle(1, 32'h0020E063, 0, 1);
    check("flush valid", 32'(out_valid), 0);
    cycle(0, 32'h0, 1, 0);
    check("flush dropped", 32'(out_valid), 0);

    cycle(1, 32'h402081B3, 0, 0);                     // asynchronous reset mid-stall
    out_ready = 0; in_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 32'(out_valid), 0);
    check("async rst in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    m_full = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0));
    cycle(0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
